// File: rtl/id_branch_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller: widths, FSM encoding, stall-need codes.
// Also holds the saturating-increment helper for the optional HAZARD_STATS_EN counters.
package id_branch_hazard_ctrl_pkg;

  localparam int REG_AW = 5;
  localparam int STAT_W = 32;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_t;

  typedef logic [1:0] need_t;

  localparam need_t NEED_NONE = 2'd0;
  localparam need_t NEED_ONE  = 2'd1;
  localparam need_t NEED_TWO  = 2'd2;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/id_branch_hazard_ctrl_if.sv
// ID/EX/MEM hazard-query bundle and stall/flush controls for id_branch_hazard_ctrl.
// Statistics outputs exist only when HAZARD_STATS_EN is defined.
interface id_branch_hazard_ctrl_if;
  import id_branch_hazard_ctrl_pkg::*;

  logic              ID_Valid;
  logic              ID_Branch;
  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic              ID_UsesRs;
  logic              ID_UsesRt;
  logic              ID_BranchTaken;
  logic              EX_RegWrite;
  logic              EX_MemRead;
  logic [REG_AW-1:0] EX_Rw;
  logic              MEM_RegWrite;
  logic              MEM_MemRead;
  logic [REG_AW-1:0] MEM_Rw;
  logic              PC_Write;
  logic              IFID_Write;
  logic              IDEX_Bubble;
  logic              IFID_Flush;
  logic              Stall;
`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] StatStallCyc;
  logic [STAT_W-1:0] StatLdBrEvt;
  logic [STAT_W-1:0] StatFlushCnt;
`endif

  modport master (
    output ID_Valid, ID_Branch, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_BranchTaken,
    output EX_RegWrite, EX_MemRead, EX_Rw, MEM_RegWrite, MEM_MemRead, MEM_Rw,
`ifdef HAZARD_STATS_EN
    input  StatStallCyc, StatLdBrEvt, StatFlushCnt,
`endif
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall
  );

  modport slave (
    input  ID_Valid, ID_Branch, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_BranchTaken,
    input  EX_RegWrite, EX_MemRead, EX_Rw, MEM_RegWrite, MEM_MemRead, MEM_Rw,
`ifdef HAZARD_STATS_EN
    output StatStallCyc, StatLdBrEvt, StatFlushCnt,
`endif
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, Stall
  );

endinterface

// File: rtl/id_branch_hazard_ctrl_hazard_dep_match.sv
// Combinational producer-to-ID dependency comparator; one instance per older stage (EX, MEM).
module hazard_dep_match
  import id_branch_hazard_ctrl_pkg::*;
(
  input  logic              reg_write,
  input  logic [REG_AW-1:0] rw,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              uses_rs,
  input  logic              uses_rt,
  output logic              dep
);

  // $0 is hardwired zero, so writing it never creates a dependency
  assign dep = reg_write && (rw != {REG_AW{1'b0}}) &&
               (((rw == rs) && uses_rs) || ((rw == rt) && uses_rt));

endmodule

// File: rtl/id_branch_hazard_ctrl.sv
// ID-stage hazard/stall controller: load-use and ALU/load-to-branch stalls, ID/EX bubble, IF/ID flush.
// Optional HAZARD_STATS_EN adds saturating stall/load-branch/flush event counters.
module id_branch_hazard_ctrl
  import id_branch_hazard_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  id_branch_hazard_ctrl_if.slave bus
);

  logic      dep_ex;
  logic      dep_mem;
  need_t     need;
  hz_state_t state;
  hz_state_t state_nxt;
  logic      cnt;
  logic      cnt_nxt;
  logic      stall;

  hazard_dep_match u_dep_ex (
    .reg_write (bus.EX_RegWrite),
    .rw        (bus.EX_Rw),
    .rs        (bus.ID_rs),
    .rt        (bus.ID_rt),
    .uses_rs   (bus.ID_UsesRs),
    .uses_rt   (bus.ID_UsesRt),
    .dep       (dep_ex)
  );

  hazard_dep_match u_dep_mem (
    .reg_write (bus.MEM_RegWrite),
    .rw        (bus.MEM_Rw),
    .rs        (bus.ID_rs),
    .rt        (bus.ID_rt),
    .uses_rs   (bus.ID_UsesRs),
    .uses_rt   (bus.ID_UsesRt),
    .dep       (dep_mem)
  );

  // Stall cycles required by the instruction in ID; EX rows take priority over MEM
  always_comb begin
    need = NEED_NONE;
    if (!bus.ID_Valid) begin
      need = NEED_NONE;
    end else if (bus.ID_Branch && dep_ex && bus.EX_MemRead) begin
      need = NEED_TWO;
    end else if (bus.ID_Branch && dep_ex) begin
      need = NEED_ONE;
    end else if (bus.ID_Branch && dep_mem && bus.MEM_MemRead) begin
      need = NEED_ONE;
    end else if (!bus.ID_Branch && dep_ex && bus.EX_MemRead) begin
      need = NEED_ONE;
    end else begin
      need = NEED_NONE;
    end
  end

  // FSM state and hold counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_RUN;
      cnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and stall decision; HOLD ignores inputs so a load-to-branch window cannot be cut short
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      ST_RUN: begin
        stall = (need != NEED_NONE);
        if (need == NEED_TWO) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = 1'b0;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        stall = 1'b1;
        if (cnt == 1'b0) begin
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        cnt_nxt   = 1'b0;
      end
    endcase
  end

  assign bus.PC_Write    = ~stall;
  assign bus.IFID_Write  = ~stall;
  assign bus.IDEX_Bubble = stall;
  assign bus.Stall       = stall;
  // Compare operands are stale while stalled, so a stall suppresses the flush
  assign bus.IFID_Flush  = bus.ID_BranchTaken && bus.ID_Valid && bus.ID_Branch && !stall;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stat_stall;
  logic [STAT_W-1:0] stat_ldbr;
  logic [STAT_W-1:0] stat_flush;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_stall <= {STAT_W{1'b0}};
      stat_ldbr  <= {STAT_W{1'b0}};
      stat_flush <= {STAT_W{1'b0}};
    end else begin
      stat_stall <= sat_inc(stat_stall, stall);
      stat_ldbr  <= sat_inc(stat_ldbr, (state == ST_RUN) && (state_nxt == ST_HOLD));
      stat_flush <= sat_inc(stat_flush, bus.IFID_Flush);
    end
  end

  assign bus.StatStallCyc = stat_stall;
  assign bus.StatLdBrEvt  = stat_ldbr;
  assign bus.StatFlushCnt = stat_flush;
`endif

endmodule
